clock_cen_ctrl: RTL and testbench

Enable sequencer that drives the CEN input of the AP3 clock input cell, which sits directly downstream of it. It accepts an asynchronous level request and synchronises it. It sequences CEN on and off with a guaranteed settle window, and reports completion through a four-phase request/acknowledge handshake. It runs in the always-on fabric clock domain and owns all gating of the gated global clock.

---
 rtl/clock_cen_ctrl_pkg.sv | 19 +
 rtl/cdc_sync_bit.sv | 25 ++
 rtl/clock_cen_ctrl.sv | 119 +++++++++++
 tb/tb_clock_cen_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_cen_ctrl_pkg.sv
// Shared clock-primitive definitions: CEN sequencer state encoding and
// settle-counter sizing helper.
package clock_cen_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    OFF        = 2'd0,
    ON_SETTLE  = 2'd1,
    ON         = 2'd2,
    OFF_SETTLE = 2'd3
  } state_e;

  // Counter must hold SETTLE_CYCLES-1 (and never be zero width).
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit flop-chain synchroniser for asynchronous level inputs.
// Synchronous active-low reset clears every stage.
module cdc_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous input through the chain; oldest sample exits at the top.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/clock_cen_ctrl.sv
// CEN sequencer for the AP3 clock input cell: synchronises EN_REQ, walks CEN
// on/off with a fixed settle window, and acknowledges via EN_ACK.
module clock_cen_ctrl
  import clock_cen_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               EN_REQ,
  input  logic               FORCE_OFF,
  output logic               CEN,
  output logic               EN_ACK,
  output logic               BUSY,
  output logic [STATE_W-1:0] STATE
);

  localparam int unsigned      CNT_W      = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic             w_req_s;
  logic             w_cut;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_cen;
  logic             w_cen_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (CLK),
    .i_rst_n(RESET_N),
    .i_d    (EN_REQ),
    .o_q    (w_req_s)
  );

  // Any reason to stop driving the clock: request withdrawn or forced off.
  assign w_cut = !w_req_s || FORCE_OFF;

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = r_ack;
    unique case (r_state)
      OFF: begin
        if (w_req_s && !FORCE_OFF) begin
          w_state_nxt = ON_SETTLE;
          w_cnt_nxt   = CNT_RELOAD;
        end
      end
      ON_SETTLE: begin
        // Abort wins over completion so EN_ACK never rises on a withdrawn request.
        if (w_cut) begin
          w_state_nxt = OFF_SETTLE;
          w_cnt_nxt   = CNT_RELOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ON;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ON: begin
        if (w_cut) begin
          w_state_nxt = OFF_SETTLE;
          w_cnt_nxt   = CNT_RELOAD;
        end
      end
      OFF_SETTLE: begin
        // Never aborted: guarantees the minimum CEN-low time.
        if (r_cnt == '0) begin
          w_state_nxt = OFF;
          w_ack_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = OFF;
        w_cnt_nxt   = '0;
        w_ack_nxt   = 1'b0;
      end
    endcase
    // Outputs are decoded from the next state so they can be flopped alongside it.
    w_cen_nxt  = (w_state_nxt == ON_SETTLE) || (w_state_nxt == ON);
    w_busy_nxt = (w_state_nxt == ON_SETTLE) || (w_state_nxt == OFF_SETTLE);
  end

  // State, counter and output registers; reset aborts straight to OFF.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_cen   <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cen   <= w_cen_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign CEN    = r_cen;
  assign EN_ACK = r_ack;
  assign BUSY   = r_busy;
  assign STATE  = r_state;

endmodule

// File: tb/tb_clock_cen_ctrl.sv
// Testbench for clock_cen_ctrl: directed vector table, hand sequences for
// multi-cycle corners, and randomized stimulus against a behavioural model.
module tb_clock_cen_ctrl;

  localparam int unsigned A_SYNC   = 2;
  localparam int unsigned A_SETTLE = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       frc;
  logic       a_cen, a_ack, a_busy;
  logic [1:0] a_st;
  logic       b_cen, b_ack, b_busy;
  logic [1:0] b_st;

  int tests;
  int fails;

  clock_cen_ctrl #(
    .SYNC_STAGES  (A_SYNC),
    .SETTLE_CYCLES(A_SETTLE)
  ) u_dut_a (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .EN_REQ   (en),
    .FORCE_OFF(frc),
    .CEN      (a_cen),
    .EN_ACK   (a_ack),
    .BUSY     (a_busy),
    .STATE    (a_st)
  );

  clock_cen_ctrl #(
    .SYNC_STAGES  (3),
    .SETTLE_CYCLES(1)
  ) u_dut_b (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .EN_REQ   (en),
    .FORCE_OFF(frc),
    .CEN      (b_cen),
    .EN_ACK   (b_ack),
    .BUSY     (b_busy),
    .STATE    (b_st)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: clock enable level, ack level, and a "settling" flag
  // with the number of edges left in the current settle window.
  bit q[$];
  bit m_cen, m_ack, m_set;
  int m_left;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int unsigned i = 0; i < A_SYNC; i++) q.push_back(1'b0);
    m_cen = 0; m_ack = 0; m_set = 0; m_left = 0;
  endtask

  task automatic model_edge();
    bit req_s, cut;
    if (!rst_n) begin
      model_reset();
    end else begin
      req_s = q[A_SYNC-1];
      cut   = !req_s || frc;
      if (m_set && !m_cen) begin
        m_left--;
        if (m_left == 0) begin m_set = 0; m_ack = 0; end
      end else if (m_set && m_cen) begin
        if (cut) begin
          m_cen = 0; m_left = A_SETTLE;
        end else begin
          m_left--;
          if (m_left == 0) begin m_set = 0; m_ack = 1; end
        end
      end else if (m_cen) begin
        if (cut) begin m_cen = 0; m_set = 1; m_left = A_SETTLE; end
      end else if (req_s && !frc) begin
        m_cen = 1; m_set = 1; m_left = A_SETTLE;
      end
      q.push_front(en);
      q.delete(A_SYNC);
    end
  endtask

  // One clock edge: advance the model, then compare DUT A against it.
  task automatic step();
    logic [1:0] m_st;
    @(posedge clk);
    model_edge();
    #1;
    m_st = m_set ? (m_cen ? 2'd1 : 2'd3) : (m_cen ? 2'd2 : 2'd0);
    chk("model_cen",   a_cen,  m_cen);
    chk("model_ack",   a_ack,  m_ack);
    chk("model_busy",  a_busy, m_set);
    chk("model_state", a_st,   m_st);
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm);
    int k = 0;
    while (a_st !== s && k < 40) begin
      step();
      k++;
    end
    chk(nm, a_st, s);
  endtask

  typedef struct {
    bit       rst_n;
    bit       en;
    bit       frc;
    bit       cen;
    bit       ack;
    bit       busy;
    bit [1:0] st;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int ack_seen, cen_seen, n_offs, low, k;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    frc   = 1'b0;
    model_reset();

    // Reset, turn-on latency, then turn-off latency (one row per edge).
    tbl.push_back('{0,0,0, 0,0,0,2'd0});
    tbl.push_back('{0,0,0, 0,0,0,2'd0});
    tbl.push_back('{1,1,0, 0,0,0,2'd0});
    tbl.push_back('{1,1,0, 0,0,0,2'd0});
    tbl.push_back('{1,1,0, 1,0,1,2'd1});
    tbl.push_back('{1,1,0, 1,0,1,2'd1});
    tbl.push_back('{1,1,0, 1,0,1,2'd1});
    tbl.push_back('{1,1,0, 1,0,1,2'd1});
    tbl.push_back('{1,1,0, 1,1,0,2'd2});
    tbl.push_back('{1,1,0, 1,1,0,2'd2});
    tbl.push_back('{1,0,0, 1,1,0,2'd2});
    tbl.push_back('{1,0,0, 1,1,0,2'd2});
    tbl.push_back('{1,0,0, 0,1,1,2'd3});
    tbl.push_back('{1,0,0, 0,1,1,2'd3});
    tbl.push_back('{1,0,0, 0,1,1,2'd3});
    tbl.push_back('{1,0,0, 0,1,1,2'd3});
    tbl.push_back('{1,0,0, 0,0,0,2'd0});
    tbl.push_back('{1,0,0, 0,0,0,2'd0});

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      en    = tbl[i].en;
      frc   = tbl[i].frc;
      step();
      chk($sformatf("tbl%0d_cen", i),   a_cen,  tbl[i].cen);
      chk($sformatf("tbl%0d_ack", i),   a_ack,  tbl[i].ack);
      chk($sformatf("tbl%0d_busy", i),  a_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_state", i), a_st,   tbl[i].st);
    end

    // Short request dropped mid ON_SETTLE: ack never rises, full OFF_SETTLE.
    ack_seen = 0; cen_seen = 0; n_offs = 0;
    for (int i = 0; i < 12; i++) begin
      en = (i < 3);
      step();
      if (a_ack === 1'b1) ack_seen++;
      if (a_cen === 1'b1) cen_seen++;
      if (a_st === 2'd3) n_offs++;
    end
    chk("s3_cen_rose", cen_seen > 0, 1);
    chk("s3_ack_never", ack_seen, 0);
    chk("s3_off_settle_len", n_offs, A_SETTLE);
    chk("s3_end_off", a_st, 2'd0);

    // Re-request during OFF_SETTLE waits for OFF; CEN low at least SETTLE cycles.
    en = 1'b1;
    wait_state(2'd2, "s4_reach_on");
    en = 1'b0;
    wait_state(2'd3, "s4_reach_off_settle");
    en = 1'b1;
    low = 0; k = 0;
    while (a_cen !== 1'b1 && k < 40) begin
      step();
      low++;
      k++;
    end
    chk("s4_cen_rises", a_cen, 1'b1);
    chk("s4_min_low", low >= A_SETTLE, 1);

    // FORCE_OFF from ON, held off, then released with request still high.
    wait_state(2'd2, "s5_reach_on");
    frc = 1'b1;
    step();
    chk("s5_cen_off", a_cen, 1'b0);
    chk("s5_off_settle", a_st, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s5_ack_hold", a_ack, 1'b1);
    end
    step();
    chk("s5_ack_drop", a_ack, 1'b0);
    chk("s5_off", a_st, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s5_stay_off", a_st, 2'd0);
    end
    frc = 1'b0;
    step();
    chk("s5_release", a_st, 2'd1);

    // Reset mid ON_SETTLE aborts; held request restarts the full sequence
    // on both parameterisations.
    step();
    rst_n = 1'b0;
    step();
    chk("s6_rst_cen",   a_cen,  1'b0);
    chk("s6_rst_ack",   a_ack,  1'b0);
    chk("s6_rst_busy",  a_busy, 1'b0);
    chk("s6_rst_state", a_st,   2'd0);
    chk("s6_rst_b_cen", b_cen,  1'b0);
    chk("s6_rst_b_ack", b_ack,  1'b0);
    chk("s6_rst_b_st",  b_st,   2'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("s6_a_cen_e%0d", e), a_cen, e >= 3);
      chk($sformatf("s6_a_ack_e%0d", e), a_ack, e >= 7);
      chk($sformatf("s6_b_cen_e%0d", e), b_cen, e >= 4);
      chk($sformatf("s6_b_ack_e%0d", e), b_ack, e >= 5);
    end

    // Randomized traffic checked against the model every cycle.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) frc = ~frc;
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
